// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, LATENCY wait states before the response.
// Define MISALIGN_TRAP_EN to flag misaligned/illegal requests via rsp_err instead of aligning.
module dmem_responder #(
  parameter int unsigned DEPTH   = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [2:0] CntInit = 3'((LATENCY == 0) ? 0 : LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          ready_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic          accept, commit;
  logic          c_we;
  logic [1:0]    c_size, eff_size, off;
  logic [AW+1:0] c_addr;
  logic [31:0]   c_wdata, wdata_sh, rd_shift, rd_mask;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic          mis;
  logic          unused_addr;

  assign unused_addr = ^req_addr[31:AW+2];
  assign accept      = req_valid & ready_q;

  assign req_ready = ready_q;
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // With LATENCY=0 the commit happens on the accept edge, so use live inputs in IDLE.
  always_comb begin
    if (state_q == StIdle) begin
      c_we    = req_we;
      c_size  = req_size;
      c_addr  = req_addr[AW+1:0];
      c_wdata = req_wdata;
    end else begin
      c_we    = we_q;
      c_size  = size_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = StResp;
            commit  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
          state_d = StResp;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    mis      = (c_size == 2'b11) || ((c_size == 2'b01) && c_addr[0]) ||
               ((c_size == 2'b10) && (c_addr[1:0] != 2'b00));
    eff_size = c_size;
    off      = c_addr[1:0];
  end
`else
  always_comb begin
    mis      = 1'b0;
    eff_size = (c_size == 2'b11) ? 2'b10 : c_size;
    case (eff_size)
      2'b00:   off = c_addr[1:0];
      2'b01:   off = {c_addr[1], 1'b0};
      default: off = 2'b00;
    endcase
  end
`endif

  always_comb begin
    idx = c_addr[AW+1:2];
    case (eff_size)
      2'b00: begin
        be      = 4'b0001 << off;
        rd_mask = 32'h0000_00ff;
      end
      2'b01: begin
        be      = 4'b0011 << off;
        rd_mask = 32'h0000_ffff;
      end
      default: begin
        be      = 4'b1111;
        rd_mask = 32'hffff_ffff;
      end
    endcase
    wdata_sh = c_wdata << {off, 3'b000};
    rd_shift = data_memory.mem[idx] >> {off, 3'b000};
  end

  if (1) begin : data_memory
    logic [31:0] mem [DEPTH];

    // Not reset, so preloads made while reset is held survive.
    always_ff @(posedge clk) begin
      if (!reset && commit && c_we && !mis) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      ready_q <= 1'b0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= (state_d == StIdle);
      if (commit) begin
        err_q   <= mis;
        rdata_q <= (c_we || mis) ? 32'h0 : (rd_shift & rd_mask);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      addr_q  <= req_addr[AW+1:0];
      wdata_q <= req_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH=32, LATENCY=1); follows MISALIGN_TRAP_EN if defined.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  dmem_responder #(
    .DEPTH  (32),
    .LATENCY(1)
  ) uut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_size (req_size),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request at a negedge; returns one negedge after the accept edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_before_issue", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk);
    // Scramble the request lines; the latched request must be used.
    req_valid = 1'b0;
    req_we    = ~we;
    req_size  = ~size;
    req_addr  = ~addr;
    req_wdata = ~wdata;
  endtask

  task automatic wait_rsp(output int cycles);
    cycles = 1;
    while (!rsp_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_size  = 2'b00;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    rsp_ready = 1'b0;

    // Reset state, with preloads made while reset is held
    @(negedge clk);
    @(negedge clk);
    uut.data_memory.mem[0]  = 32'hdead_beef;
    uut.data_memory.mem[2]  = 32'hcafe_f00d;
    uut.data_memory.mem[10] = 32'h0000_00ff;
    uut.data_memory.mem[1]  = 32'h5555_5555;
    check("reset_req_ready", {31'b0, req_ready}, 32'd0);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'h0);
    check("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_req_ready", {31'b0, req_ready}, 32'd1);

    // 1: load word, latency LATENCY+1
    issue(1'b0, 2'b10, 32'd0, 32'h0);
    wait_rsp(lat);
    check("t1_latency", 32'(lat), 32'd2);
    check("t1_rdata", rsp_rdata, 32'hdead_beef);
    check("t1_err", {31'b0, rsp_err}, 32'd0);
    finish_rsp();

    // 2: word store then byte store into the top word
    issue(1'b1, 2'b10, 32'd124, 32'h1234_5678);
    wait_rsp(lat);
    check("t2_word_mem31", uut.data_memory.mem[31], 32'h1234_5678);
    check("t2_store_rdata", rsp_rdata, 32'h0);
    finish_rsp();
    issue(1'b1, 2'b00, 32'd125, 32'h0000_00ab);
    wait_rsp(lat);
    check("t2_byte_mem31", uut.data_memory.mem[31], 32'h1234_ab78);
    finish_rsp();

    // 3: sized/shifted loads, including address wrap
    issue(1'b0, 2'b01, 32'd40, 32'h0);
    wait_rsp(lat);
    check("t3_half40", rsp_rdata, 32'h0000_00ff);
    finish_rsp();
    issue(1'b0, 2'b00, 32'd41, 32'h0);
    wait_rsp(lat);
    check("t3_byte41", rsp_rdata, 32'h0000_0000);
    finish_rsp();
    issue(1'b0, 2'b00, 32'd127, 32'h0);
    wait_rsp(lat);
    check("t3_byte127", rsp_rdata, 32'h0000_0012);
    finish_rsp();
    issue(1'b0, 2'b01, 32'd126, 32'h0);
    wait_rsp(lat);
    check("t3_half126", rsp_rdata, 32'h0000_1234);
    finish_rsp();
    issue(1'b0, 2'b00, 32'd253, 32'h0);
    wait_rsp(lat);
    check("t3_wrap_byte253", rsp_rdata, 32'h0000_00ab);
    finish_rsp();

    // 4: backpressure holds the response and blocks new requests
    issue(1'b0, 2'b10, 32'd124, 32'h0);
    wait_rsp(lat);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_addr  = 32'(i * 4);
      check("t4_hold_valid", {31'b0, rsp_valid}, 32'd1);
      check("t4_hold_rdata", rsp_rdata, 32'h1234_ab78);
      check("t4_hold_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    finish_rsp();
    check("t4_ready_after", {31'b0, req_ready}, 32'd1);
    check("t4_valid_after", {31'b0, rsp_valid}, 32'd0);

    // 5: reset during WAIT of a store drops it
    issue(1'b1, 2'b10, 32'd8, 32'h1111_1111);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t5_no_rsp", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
    end
    check("t5_mem2_kept", uut.data_memory.mem[2], 32'hcafe_f00d);
    issue(1'b0, 2'b10, 32'd0, 32'h0);
    wait_rsp(lat);
    check("t5_mem0_load", rsp_rdata, 32'hdead_beef);
    finish_rsp();

    // Reset during RESP: store already committed
    issue(1'b1, 2'b00, 32'd0, 32'h0000_0011);
    wait_rsp(lat);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5b_rsp_dropped", {31'b0, rsp_valid}, 32'd0);
    check("t5b_mem0_kept", uut.data_memory.mem[0], 32'hdead_be11);
    @(negedge clk);

    // 6: misaligned word store
    issue(1'b1, 2'b10, 32'd6, 32'h0bad_cafe);
    wait_rsp(lat);
`ifdef MISALIGN_TRAP_EN
    check("t6_err", {31'b0, rsp_err}, 32'd1);
    check("t6_rdata", rsp_rdata, 32'h0);
    check("t6_mem1_kept", uut.data_memory.mem[1], 32'h5555_5555);
    finish_rsp();
    issue(1'b0, 2'b11, 32'd0, 32'h0);
    wait_rsp(lat);
    check("t6_size11_err", {31'b0, rsp_err}, 32'd1);
    check("t6_size11_rdata", rsp_rdata, 32'h0);
    finish_rsp();
`else
    check("t6_err", {31'b0, rsp_err}, 32'd0);
    check("t6_mem1_written", uut.data_memory.mem[1], 32'h0bad_cafe);
    finish_rsp();
    issue(1'b0, 2'b01, 32'd7, 32'h0);
    wait_rsp(lat);
    check("t6_half7_aligned", rsp_rdata, 32'h0000_0bad);
    check("t6_half7_err", {31'b0, rsp_err}, 32'd0);
    finish_rsp();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
